dut_ahb_mem: RTL and testbench

- AMBA AHB-Lite slave SRAM. It is the memory target inside the FX3 USB-bridge design under test.
- The USB command path masters it to perform word, halfword and byte read/write transfers.
- Data bus is 32 bits, little-endian, with zero-wait-state OKAY transfers and a two-cycle ERROR response for unsupported transfers.
- Storage is a synchronous byte-enable RAM of MEM_SIZE bytes.

---
 rtl/dut_ahb_mem_pkg.sv | 40 ++++
 rtl/dut_ahb_mem_ram.sv | 28 ++
 rtl/dut_ahb_mem.sv | 143 ++++++++++++++
 tb/tb_dut_ahb_mem.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dut_ahb_mem_pkg.sv
// Shared AHB-Lite encodings and transfer decode helpers for the dut_ahb_mem slave SRAM.
package dut_ahb_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    RESP_OK   = 2'd0,
    RESP_ERR1 = 2'd1,
    RESP_ERR2 = 2'd2
  } resp_state_e;

  // Little-endian lane selection; only meaningful for aligned, supported sizes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b1111;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && addr_lo[0]) ||
           ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dut_ahb_mem_ram.sv
// Synchronous read-first word RAM with per-byte write enables; one clock, separate
// write and read addresses so a write commit and a new read can share an edge.
module dut_ahb_mem_ram #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             i_clk,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dut_ahb_mem.sv
// AHB-Lite slave SRAM: zero-wait OKAY reads/writes, two-cycle ERROR for unsupported
// transfers, and write-to-read byte forwarding for back-to-back same-word access.
module dut_ahb_mem
  import dut_ahb_mem_pkg::*;
#(
  parameter int MEM_SIZE   = 8192,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  SYS_CLK,
  input  logic                  SYS_RST,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic                  HREADYOUT
);

  localparam int DEPTH = MEM_SIZE / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);

  logic                  w_accept;
  logic                  w_misal;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic [3:0]            w_mask;
  logic [3:0]            w_ram_we;
  logic [31:0]           w_ram_rdata;
  logic [31:0]           w_rd_merged;
  logic                  w_unused_ok;

  logic                  r_wr_p1;
  logic [3:0]            r_wmask_p1;
  logic [IDX_W-1:0]      r_widx_p1;
  logic                  r_rdv_p1;
  logic [3:0]            r_fwd_mask_p1;
  logic [31:0]           r_fwd_data_p1;
  logic [31:0]           r_hold;
  resp_state_e           r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;

  // Address-phase decode
  assign w_accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_misal  = misaligned(HSIZE, HADDR[1:0]);
  assign w_wr     = w_accept && HWRITE && !w_misal;
  assign w_rd     = w_accept && !HWRITE && !w_misal;
  assign w_err    = w_accept && w_misal;
  assign w_word   = HADDR >> 2;
  assign w_idx    = IDX_W'(w_word) & IDX_MASK;
  assign w_mask   = lane_mask(HSIZE, HADDR[1:0]);
  assign w_ram_we = r_wr_p1 ? r_wmask_p1 : 4'b0000;

  assign w_unused_ok = ^{HBURST, HPROT, w_word};

  dut_ahb_mem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .i_clk   (SYS_CLK),
    .i_we    (w_ram_we),
    .i_waddr (r_widx_p1),
    .i_wdata (HWDATA),
    .i_re    (w_rd),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  // Address phase -> data phase (p1)
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_wr_p1       <= 1'b0;
      r_wmask_p1    <= 4'b0000;
      r_widx_p1     <= '0;
      r_rdv_p1      <= 1'b0;
      r_fwd_mask_p1 <= 4'b0000;
      r_fwd_data_p1 <= 32'h0;
      r_hold        <= 32'h0;
    end else begin
      r_wr_p1  <= w_wr;
      r_rdv_p1 <= w_rd;
      if (w_wr) begin
        r_wmask_p1 <= w_mask;
        r_widx_p1  <= w_idx;
      end
      // The RAM returns the pre-write word when a write commits on the read edge.
      if (w_rd) begin
        r_fwd_mask_p1 <= (r_wr_p1 && (r_widx_p1 == w_idx)) ? r_wmask_p1 : 4'b0000;
        r_fwd_data_p1 <= HWDATA;
      end
      if (r_rdv_p1) r_hold <= w_rd_merged;
    end
  end

  always_comb begin
    w_rd_merged = w_ram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (r_fwd_mask_p1[b]) w_rd_merged[8*b +: 8] = r_fwd_data_p1[8*b +: 8];
    end
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_state     <= RESP_OK;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      case (r_state)
        RESP_ERR1: begin
          r_state     <= RESP_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          if (w_err) begin
            r_state     <= RESP_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_ERROR;
          end else begin
            r_state     <= RESP_OK;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign HRDATA    = r_rdv_p1 ? w_rd_merged : r_hold;
  assign HRESP     = r_hresp;
  assign HREADYOUT = r_hreadyout;

endmodule

// File: tb/tb_dut_ahb_mem.sv
// Directed bench for dut_ahb_mem: single-slave bus with HREADY looped back from HREADYOUT.
module tb_dut_ahb_mem;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT;

  int n_vec = 0;
  int n_err = 0;

  assign HREADY = HREADYOUT;

  always #5 SYS_CLK = ~SYS_CLK;

  dut_ahb_mem #(.MEM_SIZE(8192), .ADDR_WIDTH(32)) dut (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .HREADYOUT (HREADYOUT)
  );

  task automatic addr_ph(input logic w, input logic [2:0] sz, input logic [31:0] a);
    @(posedge SYS_CLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HSIZE = sz; HADDR = a;
  endtask

  task automatic idle_ph();
    @(posedge SYS_CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0;
  endtask

  task automatic test_reset();
    SYS_RST = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'h3; HWDATA = 32'h0;
    repeat (2) @(posedge SYS_CLK);
    #1;
    n_vec++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want %h", HRDATA, 32'h0); end
    n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout: got %b want 1", HREADYOUT); end
    n_vec++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL rst_hresp: got %b want 0", HRESP); end
    SYS_RST = 1'b0;
  endtask

  task automatic test_word_rw();
    addr_ph(1'b1, 3'd2, 32'h10);
    idle_ph(); HWDATA = 32'hDEADBEEF;
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL word_wr_resp: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    addr_ph(1'b0, 3'd2, 32'h10);
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL word_rd_addr_resp: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    idle_ph();
    n_vec++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_rd: got %h want %h", HRDATA, 32'hDEADBEEF); end
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL word_rd_resp: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    idle_ph();
    n_vec++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold: got %h want %h", HRDATA, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_half();
    addr_ph(1'b1, 3'd0, 32'h20);
    addr_ph(1'b1, 3'd0, 32'h21); HWDATA = 32'h11111111;
    addr_ph(1'b1, 3'd0, 32'h22); HWDATA = 32'h22222222;
    addr_ph(1'b1, 3'd0, 32'h23); HWDATA = 32'h33333333;
    addr_ph(1'b0, 3'd2, 32'h20); HWDATA = 32'h44444444;
    idle_ph();
    n_vec++; if (HRDATA !== 32'h44332211) begin n_err++; $display("FAIL byte_rd: got %h want %h", HRDATA, 32'h44332211); end
    addr_ph(1'b1, 3'd1, 32'h22);
    idle_ph(); HWDATA = 32'hAAAAAAAA;
    addr_ph(1'b0, 3'd2, 32'h20);
    idle_ph();
    n_vec++; if (HRDATA !== 32'hAAAA2211) begin n_err++; $display("FAIL half_rd: got %h want %h", HRDATA, 32'hAAAA2211); end
  endtask

  task automatic test_back_to_back();
    addr_ph(1'b1, 3'd2, 32'h30);
    addr_ph(1'b0, 3'd2, 32'h30); HWDATA = 32'h12345678;
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL b2b_wr_resp: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    idle_ph();
    n_vec++; if (HRDATA !== 32'h12345678) begin n_err++; $display("FAIL b2b_word_fwd: got %h want %h", HRDATA, 32'h12345678); end
    addr_ph(1'b1, 3'd1, 32'h30);
    addr_ph(1'b0, 3'd2, 32'h30); HWDATA = 32'h0000BEEF;
    idle_ph();
    n_vec++; if (HRDATA !== 32'h1234BEEF) begin n_err++; $display("FAIL b2b_half_fwd: got %h want %h", HRDATA, 32'h1234BEEF); end
  endtask

  task automatic test_wrap();
    addr_ph(1'b1, 3'd2, 32'h2004);
    idle_ph(); HWDATA = 32'hCAFEF00D;
    addr_ph(1'b0, 3'd2, 32'h04);
    idle_ph();
    n_vec++; if (HRDATA !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_rd: got %h want %h", HRDATA, 32'hCAFEF00D); end
  endtask

  task automatic test_error();
    addr_ph(1'b1, 3'd2, 32'h40);
    idle_ph(); HWDATA = 32'h5A5A5A5A;
    addr_ph(1'b1, 3'd2, 32'h41);
    // First error cycle: keep a write to 0x40 on the bus; HREADY low must mask it.
    @(posedge SYS_CLK); #1;
    HWDATA = 32'hFFFFFFFF; HADDR = 32'h40; HSIZE = 3'd2; HWRITE = 1'b1; HTRANS = 2'b10; HSEL = 1'b1;
    n_vec++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin n_err++; $display("FAIL err_cyc1: got rdy=%b resp=%b want 0/1", HREADYOUT, HRESP); end
    idle_ph();
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin n_err++; $display("FAIL err_cyc2: got rdy=%b resp=%b want 1/1", HREADYOUT, HRESP); end
    idle_ph();
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL err_after: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    addr_ph(1'b0, 3'd2, 32'h40);
    idle_ph();
    n_vec++; if (HRDATA !== 32'h5A5A5A5A) begin n_err++; $display("FAIL err_nowrite: got %h want %h", HRDATA, 32'h5A5A5A5A); end
    addr_ph(1'b0, 3'd1, 32'h43);
    idle_ph();
    n_vec++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin n_err++; $display("FAIL err_half: got rdy=%b resp=%b want 0/1", HREADYOUT, HRESP); end
    idle_ph();
  endtask

  task automatic test_no_access();
    logic [1:0] trans_tbl [3];
    logic       sel_tbl   [3];
    trans_tbl[0] = 2'b00; sel_tbl[0] = 1'b1;
    trans_tbl[1] = 2'b01; sel_tbl[1] = 1'b1;
    trans_tbl[2] = 2'b10; sel_tbl[2] = 1'b0;
    addr_ph(1'b1, 3'd2, 32'h50);
    idle_ph(); HWDATA = 32'h01020304;
    for (int i = 0; i < 3; i++) begin
      @(posedge SYS_CLK); #1;
      HSEL = sel_tbl[i]; HTRANS = trans_tbl[i]; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h50;
      idle_ph(); HWDATA = 32'hFFFFFFFF;
      n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL noacc_resp%0d: got rdy=%b resp=%b want 1/0", i, HREADYOUT, HRESP); end
    end
    addr_ph(1'b0, 3'd2, 32'h50);
    idle_ph();
    n_vec++; if (HRDATA !== 32'h01020304) begin n_err++; $display("FAIL noacc_rd: got %h want %h", HRDATA, 32'h01020304); end
  endtask

  task automatic test_reset_mid_write();
    addr_ph(1'b1, 3'd2, 32'h10);
    idle_ph(); HWDATA = 32'h0BADF00D;
    #2 SYS_RST = 1'b1;
    #1;
    n_vec++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL midrst_hrdata: got %h want %h", HRDATA, 32'h0); end
    n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_err++; $display("FAIL midrst_resp: got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); end
    @(posedge SYS_CLK); #1;
    SYS_RST = 1'b0;
    addr_ph(1'b0, 3'd2, 32'h10);
    idle_ph();
    n_vec++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL midrst_nowrite: got %h want %h", HRDATA, 32'hDEADBEEF); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_back_to_back();
    test_wrap();
    test_error();
    test_no_access();
    test_reset_mid_write();
    repeat (2) @(posedge SYS_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
